// File: rtl/seq_det_rr_sched_pkg.sv
// Shared types and defaults for the round-robin serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int          DEF_N_CH    = 4;
    localparam int          DEF_PAT_LEN = 3;
    localparam logic [15:0] DEF_PATTERN = 16'b111;
    localparam int          DEF_CNT_W   = 16;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_det_rr_sched_if.sv
// Requester and hit-buffer handshake bundle for seq_det_rr_sched.
interface seq_det_rr_sched_if
    import seq_det_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);
    localparam int CHW = idx_w(N_CH);

    logic [N_CH-1:0] din_valid;
    logic [N_CH-1:0] din;
    logic [N_CH-1:0] din_ready;
    logic            hit_valid;
    logic [CHW-1:0]  hit_ch;
    logic            hit_ready;

    // Requesters and the hit consumer
    modport master (
        output din_valid, din, hit_ready,
        input  din_ready, hit_valid, hit_ch
    );

    // Detector
    modport slave (
        input  din_valid, din, hit_ready,
        output din_ready, hit_valid, hit_ch
    );

endinterface

// File: rtl/seq_det_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    // Walk ptr+1 .. ptr+N, grant the first requester seen
    always_comb begin
        int  c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (en && !found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = W'(c);
            end
        end
    end

endmodule

// File: rtl/seq_det_rr_sched.sv
// Shared overlapping pattern detector for N_CH serial requesters.
// Optional per-channel hit counters: define SEQ_DET_HIT_COUNT_EN.
module seq_det_rr_sched
    import seq_det_pkg::*;
#(
    parameter int                N_CH    = DEF_N_CH,
    parameter int                PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
    parameter int                CNT_W   = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    seq_det_rr_sched_if.slave      bus,
    output logic                   busy,
    input  logic [idx_w(N_CH)-1:0] cnt_sel,
    output logic [CNT_W-1:0]       cnt_val
);

    localparam int CHW = idx_w(N_CH);
    localparam int FW  = $clog2(PAT_LEN + 1);

    state_t                        state, state_nxt;
    logic [CHW-1:0]                ptr;
    logic [N_CH-1:0][PAT_LEN-1:0]  hist;
    logic [N_CH-1:0][FW-1:0]       fill;

    logic                          grant_ok;
    logic [N_CH-1:0]               gnt;
    logic [CHW-1:0]                gnt_idx;
    logic                          acc;
    logic [PAT_LEN-1:0]            nxt_hist;
    logic [FW-1:0]                 nxt_fill;
    logic                          match;

    // Grants only in RUN with en high and room in the hit buffer
    assign grant_ok = (state == RUN) && en && (!bus.hit_valid || bus.hit_ready);

    rr_arbiter #(.N(N_CH), .W(CHW)) u_arb (
        .req (bus.din_valid),
        .ptr (ptr),
        .en  (grant_ok),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign bus.din_ready = gnt;
    assign acc           = |(gnt & bus.din_valid);
    assign busy          = (state != IDLE);

    assign nxt_hist = {hist[gnt_idx][PAT_LEN-2:0], bus.din[gnt_idx]};
    assign nxt_fill = (fill[gnt_idx] == FW'(PAT_LEN)) ? FW'(PAT_LEN) : fill[gnt_idx] + FW'(1);
    assign match    = acc && (nxt_fill == FW'(PAT_LEN)) && (nxt_hist == PATTERN);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: IDLE -> CLEAR (one cycle) -> RUN, back to IDLE when en drops
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pointer follows the last transferring channel; starts at N_CH-1 so ch0 wins first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     ptr <= CHW'(N_CH - 1);
        else if (acc) ptr <= gnt_idx;
    end

    // Per-channel history and fill; only the accepted channel shifts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (state == CLEAR) begin
            hist <= '0;
            fill <= '0;
        end else if (acc) begin
            hist[gnt_idx] <= nxt_hist;
            fill[gnt_idx] <= nxt_fill;
        end
    end

    // Single-entry hit buffer; a grant is only issued when a load cannot clobber a live hit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.hit_valid <= 1'b0;
            bus.hit_ch    <= '0;
        end else if (match) begin
            bus.hit_valid <= 1'b1;
            bus.hit_ch    <= gnt_idx;
        end else if (bus.hit_valid && bus.hit_ready) begin
            bus.hit_valid <= 1'b0;
        end
    end

`ifdef SEQ_DET_HIT_COUNT_EN
    logic [N_CH-1:0][CNT_W-1:0] cnt;

    // Saturating per-channel hit counters, bumped on each hit load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= '0;
        end else if (match && (cnt[gnt_idx] != {CNT_W{1'b1}})) begin
            cnt[gnt_idx] <= cnt[gnt_idx] + CNT_W'(1);
        end
    end

    assign cnt_val = (int'(cnt_sel) < N_CH) ? cnt[cnt_sel] : '0;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_val        = '0;
`endif

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Directed bench for seq_det_rr_sched (N_CH=4, PATTERN=111).
// With SEQ_DET_HIT_COUNT_EN defined the DUT is built with CNT_W=3.
module tb_seq_det_rr_sched;
    import seq_det_pkg::*;

`ifdef SEQ_DET_HIT_COUNT_EN
    localparam int TB_CNT_W = 3;
    localparam bit CNT_ON   = 1'b1;
`else
    localparam int TB_CNT_W = 16;
    localparam bit CNT_ON   = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                busy;
    logic [1:0]          cnt_sel;
    logic [TB_CNT_W-1:0] cnt_val;

    int checks = 0;
    int errors = 0;

    seq_det_rr_sched_if #(.N_CH(4)) bus ();

    seq_det_rr_sched #(
        .N_CH    (4),
        .PAT_LEN (3),
        .PATTERN (3'b111),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .bus     (bus),
        .busy    (busy),
        .cnt_sel (cnt_sel),
        .cnt_val (cnt_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cnt_sel = 2'd0;
        bus.din_valid = '0; bus.din = '0; bus.hit_ready = 1'b0;
        #1;
        chk("rst_hit_valid", 32'(bus.hit_valid), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_din_ready", 32'(bus.din_ready), 0);
        chk("rst_hit_ch",    32'(bus.hit_ch), 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Arm: IDLE -> CLEAR -> RUN
        en = 1'b1; bus.din_valid = 4'b0001; #1;
        chk("idle_ready", 32'(bus.din_ready), 0);
        tick();
        chk("clear_busy",  32'(busy), 1);
        chk("clear_ready", 32'(bus.din_ready), 0);
        tick();
        chk("run_ready", 32'(bus.din_ready), 4'b0001);

        // Overlap on ch0: 0,1,1,1,1
        bus.hit_ready = 1'b1; bus.din = 4'b0000;
        tick();
        bus.din = 4'b0001;
        tick();
        chk("ovl_no_hit2", 32'(bus.hit_valid), 0);
        tick();
        chk("ovl_no_hit3", 32'(bus.hit_valid), 0);
        tick();
        chk("ovl_hit4", 32'(bus.hit_valid), 1);
        chk("ovl_ch4",  32'(bus.hit_ch), 0);
        tick();
        chk("ovl_hit5", 32'(bus.hit_valid), 1);
        bus.din_valid = 4'b0000;
        tick();
        chk("ovl_drain", 32'(bus.hit_valid), 0);

        // Round robin: ptr is at ch0, ch1/ch2 send 1s, ch0/ch3 send 0s
        bus.din_valid = 4'b1111; bus.din = 4'b0110; #1;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("rr_gnt%0d", i), 32'(bus.din_ready), 32'(4'b0001 << ((1 + i) % 4)));
            tick();
            chk($sformatf("rr_hv%0d", i), 32'(bus.hit_valid), (i == 8 || i == 9) ? 1 : 0);
            if (i == 8) chk("rr_ch1", 32'(bus.hit_ch), 1);
            if (i == 9) chk("rr_ch2", 32'(bus.hit_ch), 2);
        end

        // Back-pressure: ch2 hits with hit_ready low
        bus.hit_ready = 1'b0; bus.din_valid = 4'b0100; bus.din = 4'b0110; #1;
        chk("bp_gnt2", 32'(bus.din_ready), 4'b0100);
        tick();
        chk("bp_hv",  32'(bus.hit_valid), 1);
        chk("bp_ch2", 32'(bus.hit_ch), 2);
        bus.din_valid = 4'b0110; #1;
        chk("bp_stall", 32'(bus.din_ready), 0);
        tick();
        chk("bp_hold_hv", 32'(bus.hit_valid), 1);
        chk("bp_hold_ch", 32'(bus.hit_ch), 2);
        bus.hit_ready = 1'b1; #1;
        chk("bp_resume", 32'(bus.din_ready), 4'b0010);
        tick();
        chk("bp_new_hv", 32'(bus.hit_valid), 1);
        chk("bp_new_ch", 32'(bus.hit_ch), 1);

        // Disable with a pending hit (ch1 still buffered, not drained yet)
        bus.hit_ready = 1'b0; bus.din_valid = 4'b0000;
        tick();
        chk("dis_pending", 32'(bus.hit_valid), 1);
        bus.din_valid = 4'b0100; bus.din = 4'b0100; bus.hit_ready = 1'b1; #1;
        chk("dis_pre_ready", 32'(bus.din_ready), 4'b0100);
        en = 1'b0; bus.hit_ready = 1'b0; #1;
        chk("dis_ready_drop", 32'(bus.din_ready), 0);
        tick();
        chk("dis_busy",   32'(busy), 0);
        chk("dis_hv",     32'(bus.hit_valid), 1);
        chk("dis_ch",     32'(bus.hit_ch), 1);
        bus.hit_ready = 1'b1;
        tick();
        chk("dis_drained", 32'(bus.hit_valid), 0);

        // Re-arm: CLEAR wipes ch2's 1,1 so three fresh 1s are needed
        en = 1'b1; #1;
        chk("rearm_idle_ready", 32'(bus.din_ready), 0);
        tick();
        chk("rearm_clear_ready", 32'(bus.din_ready), 0);
        tick();
        chk("rearm_run_ready", 32'(bus.din_ready), 4'b0100);
        tick();
        chk("rearm_no_hit1", 32'(bus.hit_valid), 0);
        tick();
        chk("rearm_no_hit2", 32'(bus.hit_valid), 0);
        bus.hit_ready = 1'b0;
        tick();
        chk("rearm_hit3", 32'(bus.hit_valid), 1);
        chk("rearm_ch3",  32'(bus.hit_ch), 2);

        // Async reset mid-RUN with a hit pending
        bus.din_valid = 4'b0000;
        rst = 1'b0; #1;
        chk("mid_rst_hv",    32'(bus.hit_valid), 0);
        chk("mid_rst_ch",    32'(bus.hit_ch), 0);
        chk("mid_rst_busy",  32'(busy), 0);
        chk("mid_rst_ready", 32'(bus.din_ready), 0);
        tick();
        rst = 1'b1; bus.din_valid = 4'b1111; bus.din = 4'b0000; bus.hit_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_ch0_first", 32'(bus.din_ready), 4'b0001);

        // Counter: ch1 alone streams 1s; hits on accepts 3..10
        cnt_sel = 2'd1; bus.din_valid = 4'b0010; bus.din = 4'b0010;
        for (int i = 0; i < 7; i++) tick();
        chk("cnt_five", 32'(cnt_val), CNT_ON ? 5 : 0);
        chk("cnt_hv",   32'(bus.hit_valid), 1);
        for (int i = 0; i < 3; i++) tick();
        chk("cnt_sat", 32'(cnt_val), CNT_ON ? 7 : 0);
        bus.din_valid = 4'b0000; en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        tick();
        chk("cnt_cleared", 32'(cnt_val), 0);
        chk("cnt_busy",    32'(busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_rr_sched.md
Name: seq_det_rr_sched

Overview:
- Shares one overlapping serial-pattern detector among N serial bit-stream requesters.
- A round-robin scheduler accepts at most one bit per cycle through valid/ready handshakes.
- Each channel keeps its own history register. Every accepted bit is checked against a fixed pattern with overlap, so history is not cleared on a match.
- Matches go out through a single-entry hit buffer with valid/ready. A full buffer back-pressures all requesters.

Parameters:
- N_CH, 4, number of requesting channels (2..16)
- PAT_LEN, 3, pattern length in bits (2..16)
- PATTERN, 3'b111, target pattern. MSB is the oldest bit.
- CNT_W, 16, width of the per-channel hit counters (optional feature only)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- en  in  1  global enable
- din_valid  in  N_CH  per-channel bit valid
- din  in  N_CH  per-channel serial data bit
- din_ready  out  N_CH  per-channel accept. One-hot or zero; combinational from state, grant, en and the hit buffer.
- hit_valid  out  1  hit buffer holds a match
- hit_ch  out  $clog2(N_CH)  channel that produced the buffered hit
- hit_ready  in  1  downstream consumes the hit
- busy  out  1  state != IDLE
- cnt_sel  in  $clog2(N_CH)  counter select (HIT_COUNT_EN only)
- cnt_val  out  CNT_W  selected channel's hit count (HIT_COUNT_EN only)

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - state to IDLE
  - all histories and fill counts to 0
  - round-robin pointer to N_CH-1, so channel 0 has first priority
  - hit_valid=0, hit_ch=0
  - din_ready=0, busy=0
  - counters to 0
- FSM states: IDLE, CLEAR, RUN.
  - IDLE: din_ready=0. Goes to CLEAR when en=1.
  - CLEAR: lasts exactly one cycle. Zeroes every history and fill count, and the counters when compiled in. din_ready=0. Always goes to RUN.
  - RUN: scheduling active. Goes to IDLE when en=0. din_ready drops in the same cycle en falls.
- Leaving RUN retains histories, but the next CLEAR wipes them.
- A pending hit_valid survives an IDLE transition and drains normally.
- Grant:
  - In RUN, a grant is allowed only when hit_valid=0 or hit_ready=1.
  - The granted channel is the first with din_valid=1, searching from pointer+1 and wrapping modulo N_CH.
  - din_ready is high only for the granted channel.
  - The pointer updates to the granted channel only on a transfer (valid & ready). With no valid channels, the pointer holds.
- On acceptance of bit b from channel i:
  - hist[i] <= {hist[i][PAT_LEN-2:0], b}
  - fill[i] increments and saturates at PAT_LEN
- Match condition: the next fill equals PAT_LEN and the next history equals PATTERN.
  - On a match, set hit_valid=1 and hit_ch=i at the same edge.
  - Latency: hit_valid is high in the cycle after the accepting edge.
- Overlap: a channel fed PATTERN=111 followed by more 1s hits on every accepted 1 after the third.
- Hit buffer:
  - Cleared when hit_valid & hit_ready and no new hit is loaded that edge.
  - A simultaneous drain and new hit loads the new hit, with hit_valid staying 1.
  - A hit is never lost or overwritten while unconsumed.
- Boundary cases:
  - Channels that are not granted never change their history.
  - A bit with din_valid=1 but not accepted is held by the requester and must not be sampled.
  - Fewer than PAT_LEN bits since CLEAR can never produce a hit.

Optional Feature:
- Macro: SEQ_DET_HIT_COUNT_EN
- Defined:
  - Adds per-channel CNT_W-bit saturating hit counters. Each increments on the edge that loads a hit for that channel.
  - Counters are zeroed in CLEAR and on reset.
  - cnt_val = count[cnt_sel], combinational read.
- Undefined: no counters; cnt_sel is ignored and cnt_val is tied to 0.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (IDLE, CLEAR, RUN)
  - default N_CH, PAT_LEN, PATTERN, CNT_W
  - helper function for the channel index width
- Sub-module rr_arbiter:
  - inputs: N_CH request vector, pointer, enable
  - outputs: one-hot grant and encoded index; purely combinational
  - the scheduler owns the pointer register

Test Plan:
- Reset and arm: rst=0 mid-RUN with hit_valid=1 -> all outputs zero immediately. en=1 after release -> busy=1, one CLEAR cycle with din_ready=0, then RUN.
- Overlap: ch0 alone sends 0,1,1,1,1 with hit_ready=1 -> hit_valid on the cycles after the 4th and 5th accepts, hit_ch=0. No hit earlier.
- Round-robin: all four channels hold din_valid=1 -> grants 0,1,2,3,0,... one per cycle. Each channel's history contains only its own bits.
- Back-pressure: ch2 hits while hit_ready=0 -> din_ready all 0 and hit_ch=2 held. Asserting hit_ready resumes grants in the same cycle. A new hit on that edge replaces the drained one.
- Disable: en=0 during RUN with a pending hit -> din_ready=0 in the same cycle, state IDLE, hit still drains. en=1 -> CLEAR wipes histories, so 1,1 from before plus one new 1 gives no hit.
- With SEQ_DET_HIT_COUNT_EN defined: ch1 produces 5 hits -> cnt_sel=1 reads cnt_val=5. CLEAR returns it to 0. Saturation is checked at CNT_W=3 (8 hits -> reads 7).
